pkt_sf_fifo: RTL and testbench

Parametrised store-and-forward packet FIFO between a packet-beat producer and the downstream arbiter. Accepts beats with a last-word flag and exposes a packet to the reader only after its final beat has been written. It discards errored packets and packets larger than the buffer by rewinding the write pointer. Valid/ready handshakes on both sides, with occupancy, packet-count and drop status for monitoring.

---
 rtl/pkt_sf_fifo.sv | 149 ++++++++++++++
 tb/tb_pkt_sf_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_sf_fifo.sv
// pkt_sf_fifo
// Store-and-forward packet FIFO. A packet's beats are hidden from the reader
// until its final beat has been written. Errored packets, and packets too
// large to ever fit, are discarded by rewinding the speculative write pointer
// to the last commit point.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       producer handshake
//   in_data, in_last        beat payload and end-of-packet flag
//   in_err                  with in_last: discard the whole packet
//   out_valid/out_ready     consumer handshake (first-word fall-through)
//   out_data, out_last      beat at the read head
//   pkt_cnt                 committed packets not yet fully read
//   occupancy               stored beats, committed plus in-flight
//   err_drop, ovs_drop      one-cycle drop pulses (errored / oversize)
module pkt_sf_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [AW:0]       pkt_cnt,
  output logic [AW:0]       occupancy,
  output logic              err_drop,
  output logic              ovs_drop
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } state_t;

  state_t state, state_next;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] rd_ptr, wr_ptr, cm_ptr;
  logic [AW:0] wr_ptr_next, cm_ptr_next;
  logic        full, rd_en, mem_we, commit, pkt_dec, err_set, ovs_set;

  logic [DATA_W:0] mem [DEPTH];
  logic [DATA_W:0] rd_word;

  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == DEPTH_V);
  assign out_valid = (rd_ptr != cm_ptr);
  assign rd_word   = mem[rd_ptr[AW-1:0]];
  assign out_data  = rd_word[DATA_W-1:0];
  assign out_last  = rd_word[DATA_W];
  assign rd_en     = out_valid & out_ready;
  assign pkt_dec   = rd_en & out_last;

  // Write-side FSM: next state, in_ready and speculative/commit pointer updates.
  always_comb begin
    state_next  = state;
    in_ready    = 1'b1;
    wr_ptr_next = wr_ptr;
    cm_ptr_next = cm_ptr;
    mem_we      = 1'b0;
    commit      = 1'b0;
    err_set     = 1'b0;
    ovs_set     = 1'b0;
    case (state)
      ACCEPT: begin
        in_ready = ~full;
        // Whole buffer is one unfinished packet: it can never complete, so
        // give the space back and swallow the rest of it.
        if (full && (cm_ptr == rd_ptr) && (wr_ptr != cm_ptr)) begin
          wr_ptr_next = cm_ptr;
          state_next  = DROP;
        end else if (in_valid && !full) begin
          mem_we = 1'b1;
          if (in_last && in_err) begin
            wr_ptr_next = cm_ptr;
            err_set     = 1'b1;
          end else if (in_last) begin
            wr_ptr_next = wr_ptr + ONE;
            cm_ptr_next = wr_ptr + ONE;
            commit      = 1'b1;
          end else begin
            wr_ptr_next = wr_ptr + ONE;
          end
        end else begin
          wr_ptr_next = wr_ptr;
        end
      end
      DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          ovs_set    = 1'b1;
          state_next = ACCEPT;
        end else begin
          state_next = DROP;
        end
      end
      default: begin
        state_next = ACCEPT;
      end
    endcase
  end

  // State, pointers, packet counter and drop pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCEPT;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      pkt_cnt  <= '0;
      err_drop <= 1'b0;
      ovs_drop <= 1'b0;
    end else begin
      state    <= state_next;
      wr_ptr   <= wr_ptr_next;
      cm_ptr   <= cm_ptr_next;
      err_drop <= err_set;
      ovs_drop <= ovs_set;
      if (rd_en) begin
        rd_ptr <= rd_ptr + ONE;
      end
      case ({commit, pkt_dec})
        2'b10:   pkt_cnt <= pkt_cnt + ONE;
        2'b01:   pkt_cnt <= pkt_cnt - ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Beat storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
    end
  end

endmodule

// File: tb/tb_pkt_sf_fifo.sv
module tb_pkt_sf_fifo;

  localparam int DW = 16;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_last, in_err;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic [4:0]    pkt_cnt, occupancy;
  logic          err_drop, ovs_drop;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  logic [16:0] pend_q[$];
  int          model_pkt = 0;
  logic        exp_ed = 1'b0;
  logic        last_wr = 1'b0;

  pkt_sf_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_err(in_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .pkt_cnt(pkt_cnt), .occupancy(occupancy),
    .err_drop(err_drop), .ovs_drop(ovs_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        last;
    logic        err;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        chk_d;
    logic [15:0] e_d;
    logic        e_last;
    int          e_pkt;
    int          e_occ;
    logic        e_ed;
    logic        e_od;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle against the scoreboard model, with inputs already driven.
  task automatic tick_sb();
    logic [16:0] w;
    chk("sb_pkt_cnt", 32'(pkt_cnt), 32'(model_pkt));
    chk("sb_err_drop", 32'(err_drop), 32'(exp_ed));
    chk("sb_ovs_drop", 32'(ovs_drop), 32'd0);
    exp_ed  = 1'b0;
    last_wr = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_spurious_read: got data %0h expected no beat", out_data);
      end else begin
        w = exp_q.pop_front();
        chk("sb_out_data", 32'(out_data), 32'(w[15:0]));
        chk("sb_out_last", 32'(out_last), 32'(w[16]));
        if (w[16]) model_pkt--;
      end
    end
    if (last_wr) begin
      pend_q.push_back({in_last, in_data});
      if (in_last) begin
        if (in_err) begin
          pend_q.delete();
          exp_ed = 1'b1;
        end else begin
          while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
          model_pkt++;
        end
      end
    end
    tick();
  endtask

  task automatic send_pkt(input logic [7:0] id, input int len, input logic err,
                          input int vpct, input int rpct);
    int tries;
    for (int b = 0; b < len; b++) begin
      tries   = 0;
      last_wr = 1'b0;
      while (!last_wr && tries < 300) begin
        in_valid  = ($urandom_range(0, 99) < vpct);
        in_data   = {id, b[7:0]};
        in_last   = (b == len - 1);
        in_err    = in_last ? err : 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 99) < rpct);
        tick_sb();
        tries++;
      end
      if (!last_wr) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept for pkt %0h beat %0d expected accept", id, b);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0; out_ready = 1'b1;
    do begin
      tick_sb();
      n++;
    end while (exp_q.size() > 0 && n < 500);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d beats left expected 0", nm, exp_q.size());
    end
    chk({nm, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
    chk({nm, "_occupancy"}, 32'(occupancy), 32'd0);
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    //        iv  data      lst err ordy ir  ov  chk e_d       e_l pkt occ ed  od
    tbl[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'hA000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 16'hA001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'hA002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 2, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 16'hA003, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 3, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA000, 1'b0, 1, 4, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA000, 1'b0, 1, 4, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA001, 1'b0, 1, 3, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA002, 1'b0, 1, 2, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA003, 1'b1, 1, 1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0};
    // errored 3-beat packet; in_err on a non-last beat must be ignored
    tbl[11] = '{1'b1, 16'hE000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 16'hE001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 16'hE002, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 2, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 16'hB000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 16'hB001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hB000, 1'b0, 1, 2, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hB001, 1'b1, 1, 1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_err = 1'b0; out_ready = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    tick();
    rst_n = 1'b1;

    // Basic packet, then errored packet followed by a good one.
    for (int i = 0; i < 20; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].d; in_last = tbl[i].last;
      in_err = tbl[i].err; out_ready = tbl[i].ordy;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_pkt_cnt", i), 32'(pkt_cnt), 32'(tbl[i].e_pkt));
      chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("v%0d_err_drop", i), 32'(err_drop), 32'(tbl[i].e_ed));
      chk($sformatf("v%0d_ovs_drop", i), 32'(ovs_drop), 32'(tbl[i].e_od));
      if (tbl[i].chk_d) begin
        chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_d));
        chk($sformatf("v%0d_out_last", i), 32'(out_last), 32'(tbl[i].e_last));
      end
      tick();
    end

    // Oversize: 20-beat packet into a 16-entry buffer, last beat also errored.
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = 16'hC000 | 16'(k);
      in_last = (k == 19); in_err = (k == 19);
      if (k < 16) begin
        chk($sformatf("ovs_fill%0d_in_ready", k), 32'(in_ready), 32'd1);
        chk($sformatf("ovs_fill%0d_occ", k), 32'(occupancy), 32'(k));
      end else begin
        if (k == 16) begin
          chk("ovs_full_in_ready", 32'(in_ready), 32'd0);
          chk("ovs_full_occ", 32'(occupancy), 32'd16);
          tick();
        end
        chk($sformatf("ovs_drop%0d_in_ready", k), 32'(in_ready), 32'd1);
        chk($sformatf("ovs_drop%0d_occ", k), 32'(occupancy), 32'd0);
        chk($sformatf("ovs_drop%0d_pulse", k), 32'(ovs_drop), 32'd0);
      end
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
    chk("ovs_pulse", 32'(ovs_drop), 32'd1);
    chk("ovs_no_err_pulse", 32'(err_drop), 32'd0);
    chk("ovs_after_occ", 32'(occupancy), 32'd0);
    chk("ovs_after_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("ovs_pulse_width", 32'(ovs_drop), 32'd0);
    send_pkt(8'h51, 2, 1'b0, 100, 0);
    drain("ovs_next");

    // Fill with eight 2-beat packets, then read and write concurrently.
    for (int p = 0; p < 8; p++) send_pkt(8'hD0 + 8'(p), 2, 1'b0, 100, 0);
    chk("fill_occ", 32'(occupancy), 32'd16);
    chk("fill_pkt_cnt", 32'(pkt_cnt), 32'd8);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 16'hE100; in_last = 1'b0; in_err = 1'b0; out_ready = 1'b1;
    tick_sb();
    chk("fill_in_ready_after_read", 32'(in_ready), 32'd1);
    for (int p = 0; p < 8; p++) send_pkt(8'hE1 + 8'(p), 2, 1'b0, 100, 100);
    drain("fill");

    // Random traffic across many pointer wraps.
    for (int p = 0; p < 100; p++)
      send_pkt(8'(p), $urandom_range(1, 16), ($urandom_range(0, 9) == 0), 70, 60);
    drain("rand");

    // Reset mid-packet with two committed packets stored.
    send_pkt(8'h71, 2, 1'b0, 100, 0);
    send_pkt(8'h72, 2, 1'b0, 100, 0);
    in_valid = 1'b1; in_data = 16'h7300; in_last = 1'b0; in_err = 1'b0; out_ready = 1'b0;
    tick();
    in_data = 16'h7301;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("mid_rst_occupancy", 32'(occupancy), 32'd0);
    chk("mid_rst_err_drop", 32'(err_drop), 32'd0);
    chk("mid_rst_ovs_drop", 32'(ovs_drop), 32'd0);
    tick();
    rst_n = 1'b1;
    exp_q.delete(); pend_q.delete(); model_pkt = 0; exp_ed = 1'b0;
    send_pkt(8'h7F, 3, 1'b0, 100, 0);
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
